// File: rtl/memory_bus_arbiter.sv
// Two-requester arbiter (fetch, data) for a single 32-bit memory bus.
// Ports: clk, reset (async active-low), fetch_* / data_* requester sides,
//   mem_* memory side, bus_error timeout pulse coincident with done.
module memory_bus_arbiter #(
   parameter int MAX_DATA_STREAK = 3,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   input  logic        fetch_flush,
   output logic        fetch_done,
   output logic [31:0] fetch_rdata,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_done,
   output logic [31:0] data_rdata,
   output logic        bus_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam int SW = (MAX_DATA_STREAK > 0) ?
                       $clog2(MAX_DATA_STREAK + 1) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ?
                       $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SW-1:0] S_MAX = SW'(MAX_DATA_STREAK);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH_BUSY,
      DATA_BUSY,
      DONE
   } state_t;

   state_t        state;
   logic          own_data;
   logic          flush_pend;
   logic          err;
   logic [SW-1:0] streak;
   logic [TW-1:0] tcnt;
   logic          in_done;
   logic          fetch_win;

   // Fetch wins when it is not being flushed and data is either idle
   // or has already had its maximum run of grants.
   assign fetch_win = fetch_req && !fetch_flush &&
                      ((streak == S_MAX) || !data_req);

   // A flush seen during the done cycle itself still suppresses it.
   assign in_done    = (state == DONE);
   assign fetch_done = in_done && !own_data &&
                       !flush_pend && !fetch_flush;
   assign data_done  = in_done && own_data;
   assign bus_error  = err && (fetch_done || data_done);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         own_data    <= 1'b0;
         flush_pend  <= 1'b0;
         err         <= 1'b0;
         streak      <= '0;
         tcnt        <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         fetch_rdata <= '0;
         data_rdata  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               tcnt <= '0;
               if (fetch_win) begin
                  state     <= FETCH_BUSY;
                  own_data  <= 1'b0;
                  streak    <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= fetch_addr;
                  mem_wdata <= '0;
               end else if (data_req) begin
                  state     <= DATA_BUSY;
                  own_data  <= 1'b1;
                  mem_req   <= 1'b1;
                  mem_we    <= data_we;
                  mem_addr  <= data_addr;
                  mem_wdata <= data_wdata;
                  if (!fetch_req)
                     streak <= '0;
                  else if (streak != S_MAX)
                     streak <= streak + SW'(1);
               end
            end
            FETCH_BUSY, DATA_BUSY: begin
               if (state == FETCH_BUSY && fetch_flush)
                  flush_pend <= 1'b1;
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= DONE;
                  if (!mem_we) begin
                     if (own_data)
                        data_rdata <= mem_rdata;
                     else
                        fetch_rdata <= mem_rdata;
                  end
               end else if (tcnt == T_MAX) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  state   <= DONE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            DONE: begin
               state      <= IDLE;
               flush_pend <= 1'b0;
               err        <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
